// File: rtl/ir_xmit.sv
// ---------------------------------------------------------------------------
// ir_xmit -- NEC infrared transmitter.
//
// Sends a full NEC frame (16T lead mark, 8T lead space, 32 data bits, 1T stop
// mark) or a NEC repeat code (16T lead mark, 4T space, 1T stop mark). Either
// one is followed by a mandatory idle gap of GAP_UNITS*T.
//
// Ports:
//   clk27      in   sole clock
//   reset_n    in   asynchronous active-low reset
//   ir_code    in   [15:8] address, [7:0] command; latched when send is taken
//   send       in   start request, looked at every cycle while idle
//   rpt        in   with an accepted send, transmit a repeat code instead
//   busy       out  transmission or gap in progress
//   ir_tx      out  carrier-modulated LED drive, high = LED on
//   ir_env_n   out  unmodulated envelope, low during marks, idle high
//   frame_done out  one-cycle pulse in the last gap cycle
//   dbg_state  out  current FSM state encoding
//
// Handshake: send is a level request. It is taken in any cycle where busy is
// low (the frame_done cycle still has busy high, so it is not taken there);
// while busy is high it is ignored and nothing is queued.
// ---------------------------------------------------------------------------
module ir_xmit #(
  parameter int UNIT_CYCLES = 15188,
  parameter int CARRIER_DIV = 711,
  parameter int GAP_UNITS   = 72
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic [15:0] ir_code,
  input  logic        send,
  input  logic        rpt,
  output logic        busy,
  output logic        ir_tx,
  output logic        ir_env_n,
  output logic        frame_done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    REP_SPACE  = 3'd3,
    BIT_MARK   = 3'd4,
    BIT_SPACE  = 3'd5,
    STOP_MARK  = 3'd6,
    GAP        = 3'd7
  } state_t;

  localparam int CW       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int UNIT_MAX = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int UW       = $clog2(UNIT_MAX);
  localparam int KW       = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [KW-1:0] CAR_LAST = KW'(CARRIER_DIV - 1);
  localparam logic [KW-1:0] CAR_HALF = KW'(CARRIER_DIV / 2);
  localparam logic [UW-1:0] GAP_LAST = UW'(GAP_UNITS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;        // cycle within the current unit
  logic [UW-1:0] units_q, units_d;    // unit within the current state
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [31:0]   data_q, data_d;
  logic          rpt_q, rpt_d;
  logic [KW-1:0] car_q, car_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic          env_n_q, env_n_d;
  logic          done_q, done_d;

  logic          cur_bit;
  logic [UW-1:0] len_m1;
  logic          unit_end;
  logic          state_end;
  logic          mark_q;
  logic          mark_d;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    units_d   = units_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    rpt_d     = rpt_q;
    cur_bit   = data_q[bit_idx_q];

    // Length of the current state in units, minus one.
    len_m1 = '0;
    case (state_q)
      LEAD_MARK:  len_m1 = UW'(15);
      LEAD_SPACE: len_m1 = UW'(7);
      REP_SPACE:  len_m1 = UW'(3);
      BIT_SPACE:  len_m1 = cur_bit ? UW'(2) : UW'(0);
      GAP:        len_m1 = GAP_LAST;
      default:    len_m1 = '0;
    endcase

    unit_end  = (cyc_q == CYC_LAST);
    state_end = (state_q != IDLE) && unit_end && (units_q == len_m1);

    if (state_q != IDLE) begin
      cyc_d = unit_end ? '0 : cyc_q + 1'b1;
      if (state_end)     units_d = '0;
      else if (unit_end) units_d = units_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (send) begin
          state_d   = LEAD_MARK;
          // Transmission order is bit 0 first: address, ~address, command, ~command.
          data_d    = {~ir_code[7:0], ir_code[7:0], ~ir_code[15:8], ir_code[15:8]};
          rpt_d     = rpt;
          bit_idx_d = '0;
          cyc_d     = '0;
          units_d   = '0;
        end
      end
      LEAD_MARK:  if (state_end) state_d = rpt_q ? REP_SPACE : LEAD_SPACE;
      LEAD_SPACE: if (state_end) state_d = BIT_MARK;
      REP_SPACE:  if (state_end) state_d = STOP_MARK;
      BIT_MARK:   if (state_end) state_d = BIT_SPACE;
      BIT_SPACE: begin
        if (state_end) begin
          bit_idx_d = bit_idx_q + 1'b1;
          state_d   = (bit_idx_q == 5'd31) ? STOP_MARK : BIT_MARK;
        end
      end
      STOP_MARK:  if (state_end) state_d = GAP;
      GAP:        if (state_end) state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    mark_q = (state_q == LEAD_MARK) || (state_q == BIT_MARK) || (state_q == STOP_MARK);
    mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

    // Marks never follow marks directly, so entering a mark restarts the
    // carrier phase and every mark begins with the LED on.
    if (!mark_d || !mark_q) car_d = '0;
    else if (car_q == CAR_LAST) car_d = '0;
    else car_d = car_q + 1'b1;

    // Outputs are registered from next-state values so they line up with state_q.
    busy_d  = (state_d != IDLE);
    env_n_d = !mark_d;
    tx_d    = mark_d && (car_d < CAR_HALF);
    done_d  = (state_d == GAP) && (cyc_d == CYC_LAST) && (units_d == GAP_LAST);
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      units_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      rpt_q     <= 1'b0;
      car_q     <= '0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b0;
      env_n_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      units_q   <= units_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      rpt_q     <= rpt_d;
      car_q     <= car_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
      env_n_q   <= env_n_d;
      done_q    <= done_d;
    end
  end

  assign busy       = busy_q;
  assign ir_tx      = tx_q;
  assign ir_env_n   = env_n_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ir_xmit.sv
// ---------------------------------------------------------------------------
// tb_ir_xmit -- self-checking bench for ir_xmit with short units.
// Two instances share the stimulus: one with CARRIER_DIV=2, one with
// CARRIER_DIV=4. Expected envelopes come from a small NEC encoder model.
// ---------------------------------------------------------------------------
module tb_ir_xmit;
  localparam int U    = 4;
  localparam int GAPU = 2;

  // ---------------- clock / reset ----------------
  logic        clk27   = 1'b0;
  logic        reset_n = 1'b0;
  logic        send    = 1'b0;
  logic        rpt     = 1'b0;
  logic [15:0] ir_code = 16'h0000;

  logic       busy, ir_tx, ir_env_n, frame_done;
  logic [2:0] dbg_state;
  logic       busy4, ir_tx4, ir_env_n4, frame_done4;
  logic [2:0] dbg_state4;

  always #5 clk27 = ~clk27;

  ir_xmit #(.UNIT_CYCLES(U), .CARRIER_DIV(2), .GAP_UNITS(GAPU)) dut (
    .clk27(clk27), .reset_n(reset_n), .ir_code(ir_code), .send(send), .rpt(rpt),
    .busy(busy), .ir_tx(ir_tx), .ir_env_n(ir_env_n), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  ir_xmit #(.UNIT_CYCLES(U), .CARRIER_DIV(4), .GAP_UNITS(GAPU)) dut4 (
    .clk27(clk27), .reset_n(reset_n), .ir_code(ir_code), .send(send), .rpt(rpt),
    .busy(busy4), .ir_tx(ir_tx4), .ir_env_n(ir_env_n4), .frame_done(frame_done4),
    .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];     // expected ir_env_n per busy cycle
  logic [0:0] exp_tx2_q[$];
  logic [0:0] exp_tx4_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_seg(input logic v, input int units);
    for (int k = 0; k < units * U; k++) exp_q.push_back(v);
  endfunction

  // NEC encoder model: 0 = mark (envelope low), 1 = space.
  function automatic void build_model(input logic [15:0] code, input logic r);
    logic [31:0] word;
    int          c;
    exp_q.delete();
    exp_tx2_q.delete();
    exp_tx4_q.delete();
    push_seg(1'b0, 16);
    if (r) begin
      push_seg(1'b1, 4);
    end else begin
      push_seg(1'b1, 8);
      word = {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
      for (int b = 0; b < 32; b++) begin
        push_seg(1'b0, 1);
        push_seg(1'b1, word[b] ? 3 : 1);
      end
    end
    push_seg(1'b0, 1);
    push_seg(1'b1, GAPU);
    c = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i] == 1'b0) begin
        if (i == 0 || exp_q[i-1] == 1'b1) c = 0;
        else c++;
        exp_tx2_q.push_back(((c % 2) < 1) ? 1'b1 : 1'b0);
        exp_tx4_q.push_back(((c % 4) < 2) ? 1'b1 : 1'b0);
      end else begin
        exp_tx2_q.push_back(1'b0);
        exp_tx4_q.push_back(1'b0);
      end
    end
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at the negedge of the first
  // idle cycle after the frame so the next call starts back-to-back.
  task automatic run_frame(input logic [15:0] code, input logic r, input bit pester,
                           input int exp_len, input string tag);
    int env_bad = 0, tx_bad = 0, tx4_bad = 0, busy_bad = 0, done_bad = 0, done_cnt = 0;
    logic e, t2, t4;
    build_model(code, r);
    send = 1'b1; rpt = r; ir_code = code;
    @(negedge clk27);
    check({tag, "_first_state"}, int'(dbg_state), 1);
    for (int i = 0; i < exp_len; i++) begin
      e  = (i < exp_q.size()) ? exp_q[i]     : 1'b1;
      t2 = (i < exp_q.size()) ? exp_tx2_q[i] : 1'b0;
      t4 = (i < exp_q.size()) ? exp_tx4_q[i] : 1'b0;
      if (ir_env_n !== e || ir_env_n4 !== e) env_bad++;
      if (ir_tx !== t2) tx_bad++;
      if (ir_tx4 !== t4) tx4_bad++;
      if (busy !== 1'b1 || busy4 !== 1'b1) busy_bad++;
      if (frame_done !== (i == exp_len - 1) || frame_done4 !== frame_done) done_bad++;
      if (frame_done === 1'b1) done_cnt++;
      if (pester) begin
        // Also request in the frame_done cycle, which must be ignored.
        send    = (i == exp_len - 1) ? 1'b1 : 1'($urandom_range(0, 1));
        rpt     = 1'($urandom_range(0, 1));
        ir_code = 16'($urandom_range(0, 65535));
      end else begin
        send = 1'b0;
      end
      @(negedge clk27);
    end
    send = 1'b0;
    check({tag, "_env_wave_bad"}, env_bad, 0);
    check({tag, "_tx2_wave_bad"}, tx_bad, 0);
    check({tag, "_tx4_wave_bad"}, tx4_bad, 0);
    check({tag, "_busy_wave_bad"}, busy_bad, 0);
    check({tag, "_done_wave_bad"}, done_bad, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_idle_env_n"}, int'(ir_env_n), 1);
  endtask

  typedef struct {
    logic [15:0] code;
    logic        r;
    bit          pester;
    int          exp_len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int done_cnt;
    vecs[0] = '{code: 16'h00FF, r: 1'b0, pester: 1'b0, exp_len: 492};
    vecs[1] = '{code: 16'h00FF, r: 1'b1, pester: 1'b0, exp_len: 92};
    vecs[2] = '{code: 16'h1AE5, r: 1'b0, pester: 1'b0, exp_len: 492};
    vecs[3] = '{code: 16'hA55A, r: 1'b0, pester: 1'b1, exp_len: 492};
    vecs[4] = '{code: 16'hFFFF, r: 1'b1, pester: 1'b1, exp_len: 92};
    vecs[5] = '{code: 16'h0000, r: 1'b0, pester: 1'b0, exp_len: 492};

    // Reset state, with a send request held during reset.
    send = 1'b1;
    repeat (3) @(negedge clk27);
    check("rst_busy", int'(busy), 0);
    check("rst_env_n", int'(ir_env_n), 1);
    check("rst_tx", int'(ir_tx), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_state", int'(dbg_state), 0);
    send = 1'b0;
    reset_n = 1'b1;
    @(negedge clk27);

    for (int k = 0; k < 6; k++)
      run_frame(vecs[k].code, vecs[k].r, vecs[k].pester, vecs[k].exp_len, $sformatf("v%0d", k));

    // Reset in the middle of bit 10 of a 0x00FF frame (bit 10 mark starts at 192).
    send = 1'b1; rpt = 1'b0; ir_code = 16'h00FF;
    @(negedge clk27);
    send = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 194; i++) begin
      if (frame_done === 1'b1) done_cnt++;
      @(negedge clk27);
    end
    check("bit10_env_n", int'(ir_env_n), 0);
    check("bit10_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_env_n", int'(ir_env_n), 1);
    check("midrst_tx", int'(ir_tx), 0);
    check("midrst_tx4", int'(ir_tx4), 0);
    check("midrst_state", int'(dbg_state), 0);
    check("midrst_no_done", done_cnt, 0);
    @(negedge clk27);
    reset_n = 1'b1;
    @(negedge clk27);
    check("postrst_idle", int'(busy), 0);
    run_frame(16'h00FF, 1'b0, 1'b0, 492, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_xmit.md
IR_XMIT -- requirements
Module: ir_xmit

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 15188, clk27 cycles per NEC unit T (562.5 us at 27 MHz).
REQ-002 SHALL have parameter CARRIER_DIV, default 711, clk27 cycles per carrier period (~37.97 kHz).
REQ-003 SHALL have parameter GAP_UNITS, default 72, mandatory idle units after each transmission.
REQ-004 SHALL have port clk27  in  1  sole clock.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port ir_code  in  16  [15:8] address, [7:0] command.
REQ-007 SHALL have port send  in  1  start request, sampled every cycle.
REQ-008 SHALL have port rpt  in  1  when high with accepted send, transmit NEC repeat code instead of a full frame.
REQ-009 SHALL have port busy  out  1  transmission or gap in progress.
REQ-010 SHALL have port ir_tx  out  1  carrier-modulated LED drive, high = LED on.
REQ-011 SHALL have port ir_env_n  out  1  unmodulated envelope, low during mark, idle high (loopback-compatible with ir_rcv ir_rx).
REQ-012 SHALL have port frame_done  out  1  single-cycle pulse at end of gap.

Function
REQ-013 SHALL accept send only when busy=0; ir_code and rpt latched in the accept cycle; send while busy=1 ignored, no queuing.
REQ-014 SHALL assert busy and drive ir_env_n=0 starting the cycle after acceptance.
REQ-015 SHALL use states IDLE, LEAD_MARK, LEAD_SPACE, REP_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
REQ-016 Full frame SHALL be: LEAD_MARK 16T, LEAD_SPACE 8T, 32 bits, STOP_MARK 1T, GAP GAP_UNITS*T.
REQ-017 Bit sequence SHALL be address, ~address, command, ~command, each byte LSB first.
REQ-018 Each bit SHALL be BIT_MARK 1T then BIT_SPACE 1T for '0' or 3T for '1'.
REQ-019 Repeat code (rpt=1) SHALL be: LEAD_MARK 16T, REP_SPACE 4T, STOP_MARK 1T, GAP; ir_code ignored.
REQ-020 Full frame busy duration SHALL be exactly (121+GAP_UNITS)*UNIT_CYCLES cycles for any ir_code (16 ones always); repeat (21+GAP_UNITS)*UNIT_CYCLES.
REQ-021 ir_env_n SHALL be 0 in all *_MARK states, 1 otherwise.
REQ-022 Carrier counter SHALL clear to 0 at every mark start and wrap at CARRIER_DIV-1; ir_tx = mark & (count < CARRIER_DIV/2 using integer division).
REQ-023 ir_tx SHALL be 0 in all space, GAP and IDLE states.
REQ-024 Unit counter SHALL wrap at UNIT_CYCLES-1; bit index 0..31 SHALL advance after each BIT_SPACE; after bit 31 go to STOP_MARK.
REQ-025 frame_done SHALL pulse in the final GAP cycle; busy=0 from the following cycle; send in the frame_done cycle ignored.
REQ-026 A send accepted in the first cycle busy=0 SHALL start the next transmission with no extra idle cycle.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, busy=0, ir_tx=0, ir_env_n=1, frame_done=0, all counters and latched code 0.
REQ-028 Reset mid-transmission SHALL abort the frame without frame_done; first send after release SHALL start a complete new frame.

Verification (UNIT_CYCLES=4, CARRIER_DIV=2, GAP_UNITS=2 unless noted)
REQ-029 send=1, rpt=0, ir_code=0x00FF -> ir_env_n low 64 cycles, high 32, then bits with space 4/12 cycles matching 0x00,0xFF,0xFF,0x00 LSB first, stop low 4; busy exactly 123*4=492 cycles; one frame_done.
REQ-030 send=1, rpt=1 -> ir_env_n low 64, high 16, low 4, high 8; busy 92 cycles; frame_done once.
REQ-031 send pulsed repeatedly while busy -> no change in waveform, exactly one frame_done.
REQ-032 reset_n=0 during bit 10 -> same cycle ir_tx=0, ir_env_n=1, busy=0; new send after release yields full correct frame.
REQ-033 CARRIER_DIV=4 during LEAD_MARK -> ir_tx pattern 1,1,0,0 repeating, starting high at mark start; 0 in all spaces.
REQ-034 Default parameters, ir_env_n looped to ir_rcv ir_rx, ir_code=0x1AE5 -> ir_rcv reports ir_code 0x1AE5 and ir_code_cnt increments by 1.
